// File: rtl/ram_rr_arbiter.sv
// ram_rr_arbiter: round-robin sequencer sharing one single-port RAM between two requesters; define ARB_STATS_EN for per-port grant counters
module ram_rr_arbiter #(
  parameter int DATA_W = 2,
  parameter int ADDR_W = 2
`ifdef ARB_STATS_EN
  ,
  parameter int CNT_W = 8
`endif
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
`ifdef ARB_STATS_EN
  output logic [CNT_W-1:0]  gcnt0,
  output logic [CNT_W-1:0]  gcnt1,
  input  logic [DATA_W-1:0] ram_rdata
`else
  input  logic [DATA_W-1:0] ram_rdata
`endif
);
  localparam logic [1:0] IDLE = 2'd0, ACCESS = 2'd1, WAIT = 2'd2, RESP = 2'd3;
  logic [1:0] state;
  logic       last_grant;
  logic       gnt;
  logic       l_we;
  logic       pick1;
  // port 1 wins when alone, or when both ask and port 0 was served last
  always_comb pick1 = req1 & (~req0 | ~last_grant);
  // access sequencer: grant, strobe the RAM, capture read data, pulse done
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      gnt        <= 1'b0;
      l_we       <= 1'b0;
      done0      <= 1'b0;
      done1      <= 1'b0;
      rdata0     <= '0;
      rdata1     <= '0;
      ram_en     <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
    end else begin
      case (state)
        IDLE: if (req0 | req1) begin
          state      <= ACCESS;
          gnt        <= pick1;
          last_grant <= pick1;
          l_we       <= pick1 ? we1 : we0;
          ram_en     <= 1'b1;
          ram_we     <= pick1 ? we1 : we0;
          ram_addr   <= pick1 ? addr1 : addr0;
          ram_wdata  <= pick1 ? wdata1 : wdata0;
        end
        ACCESS: begin
          state  <= WAIT;
          ram_en <= 1'b0;
          ram_we <= 1'b0;
        end
        WAIT: begin
          state <= RESP;
          done0 <= ~gnt;
          done1 <= gnt;
          if (!l_we && !gnt) rdata0 <= ram_rdata;
          if (!l_we && gnt) rdata1 <= ram_rdata;
        end
        RESP: begin
          state <= IDLE;
          done0 <= 1'b0;
          done1 <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          ram_en <= 1'b0;
          ram_we <= 1'b0;
          done0  <= 1'b0;
          done1  <= 1'b0;
        end
      endcase
    end
  end
`ifdef ARB_STATS_EN
  // saturating count of completed accesses per port
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      gcnt0 <= '0;
      gcnt1 <= '0;
    end else begin
      if (done0 && !(&gcnt0)) gcnt0 <= gcnt0 + CNT_W'(1);
      if (done1 && !(&gcnt1)) gcnt1 <= gcnt1 + CNT_W'(1);
    end
  end
`endif
endmodule
